// File: rtl/codec_dac_dma_master_pkg.sv
// Shared types and constants for the codec DAC DMA read master.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state encoding, word size, burst-count width, burst clipping helper.
package codec_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        REQ   = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BCOUNT_W   = 8;

    // Burst length actually issued: a request of 0 means 1, never more than
    // the configured maximum, never more than the words still owed.
    function automatic logic [BCOUNT_W-1:0] clip_burst(
        input logic [BCOUNT_W-1:0] req_len,
        input logic [15:0]         rem_words,
        input logic [BCOUNT_W-1:0] max_len
    );
        logic [15:0] l;
        l = (req_len == '0) ? 16'd1 : {8'd0, req_len};
        if (l > {8'd0, max_len}) l = {8'd0, max_len};
        if (l > rem_words)       l = rem_words;
        return l[BCOUNT_W-1:0];
    endfunction

endpackage

// File: rtl/codec_dac_dma_master_if.sv
// Avalon-MM burst read bus plus DAC FIFO write port of the DMA master.
// Latency: n/a (wires only).
// Backpressure: master_waitrequest stalls requests; FIFO side has none (space reserved up front).
// Modports: master (DMA block side), slave (memory + FIFO side).
interface codec_dac_dma_master_if
    import codec_dma_pkg::*;
#(
    parameter int FREE_W = 9
) ();

    logic [31:0]         master_address;
    logic                master_read;
    logic [BCOUNT_W-1:0] master_burstcount;
    logic                master_waitrequest;
    logic [31:0]         master_readdata;
    logic                master_readdatavalid;
    logic                dac_fifo_wr;
    logic [31:0]         dac_fifo_data;
    logic [FREE_W-1:0]   dac_fifo_free;

    modport master (
        output master_address, master_read, master_burstcount,
        input  master_waitrequest, master_readdata, master_readdatavalid,
        output dac_fifo_wr, dac_fifo_data,
        input  dac_fifo_free
    );

    modport slave (
        input  master_address, master_read, master_burstcount,
        output master_waitrequest, master_readdata, master_readdatavalid,
        input  dac_fifo_wr, dac_fifo_data,
        output dac_fifo_free
    );

endinterface

// File: rtl/codec_dac_dma_master_burst_counter.sv
// Beat counter for one read burst: load with the burst length, count down per beat.
// Latency: count updates on the clock after load/dec; last is combinational from count.
// Backpressure: none; dec is ignored once the count is already zero.
// Ports: Clk, Rst_n (sync, active-high), load/load_val, dec, last (count==1).
module codec_burst_counter
    import codec_dma_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                load,
    input  logic                dec,
    input  logic [BCOUNT_W-1:0] load_val,
    output logic                last
);

    logic [BCOUNT_W-1:0] count;

    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == BCOUNT_W'(1));

endmodule

// File: rtl/codec_dac_dma_master.sv
// Avalon-MM burst read master: streams 32-bit DAC samples from memory into the DAC FIFO.
// Latency: request one cycle after FIFO space is seen; each read beat reaches the FIFO one cycle later.
// Backpressure: waits in CHECK until the FIFO can hold the whole burst; honours master_waitrequest.
// Ports: Clk, Rst_n (sync, active-high); cfg_* software controls; busy/done/aborted status;
//        irq (with irq_clr input only when CODEC_DMA_IRQ_EN is defined, otherwise tied 0);
//        bus = Avalon read master + DAC FIFO write port (codec_dac_dma_master_if.master).
module codec_dac_dma_master
    import codec_dma_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int FREE_W    = 9
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        cfg_start,
    input  logic [31:0] cfg_base_addr,
    input  logic [15:0] cfg_num_words,
    input  logic [7:0]  cfg_burst_len,
    input  logic        cfg_abort,
    output logic        busy,
    output logic        done,
    output logic        aborted,
`ifdef CODEC_DMA_IRQ_EN
    input  logic        irq_clr,
`endif
    output logic        irq,
    codec_dac_dma_master_if.master bus
);

    state_t              state;
    logic [31:0]         addr;
    logic [15:0]         remaining;
    logic                abort_seen;
    logic [BCOUNT_W-1:0] len;
    logic [31:0]         free_ext;
    logic                beat_load;
    logic                beat_dec;
    logic                beat_last;

    // Burst length follows the live cfg_burst_len so software may retune it
    // between bursts; base address and word count are frozen at start.
    assign len      = clip_burst(cfg_burst_len, remaining, BCOUNT_W'(BURST_MAX));
    assign free_ext = 32'(bus.dac_fifo_free);

    assign beat_load = (state == REQ)  && !bus.master_waitrequest;
    assign beat_dec  = (state == DATA) && bus.master_readdatavalid;

    codec_burst_counter u_beat_cnt (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .load     (beat_load),
        .dec      (beat_dec),
        .load_val (bus.master_burstcount),
        .last     (beat_last)
    );

    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            state                 <= IDLE;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            aborted               <= 1'b0;
            abort_seen            <= 1'b0;
            addr                  <= '0;
            remaining             <= '0;
            bus.master_read       <= 1'b0;
            bus.master_address    <= '0;
            bus.master_burstcount <= '0;
            bus.dac_fifo_wr       <= 1'b0;
            bus.dac_fifo_data     <= '0;
        end else begin
            done            <= 1'b0;
            bus.dac_fifo_wr <= 1'b0;

            // Abort is latched for the whole transfer but only acted on at a
            // burst boundary, since an issued Avalon burst must be drained.
            if (state != IDLE && cfg_abort) begin
                abort_seen <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        addr       <= cfg_base_addr & ~32'(WORD_BYTES - 1);
                        remaining  <= cfg_num_words;
                        busy       <= 1'b1;
                        aborted    <= 1'b0;
                        abort_seen <= 1'b0;
                        if (cfg_num_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    if (abort_seen || cfg_abort) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (free_ext >= 32'(len)) begin
                        // Nothing is in flight here, so the whole burst must fit.
                        state                 <= REQ;
                        bus.master_read       <= 1'b1;
                        bus.master_address    <= addr;
                        bus.master_burstcount <= len;
                    end
                end

                REQ: begin
                    if (!bus.master_waitrequest) begin
                        bus.master_read <= 1'b0;
                        state           <= DATA;
                    end
                end

                DATA: begin
                    if (bus.master_readdatavalid) begin
                        bus.dac_fifo_wr   <= 1'b1;
                        bus.dac_fifo_data <= bus.master_readdata;
                        remaining         <= remaining - 16'd1;
                        if (beat_last) begin
                            addr <= addr + 32'(bus.master_burstcount) * 32'(WORD_BYTES);
                            if (remaining == 16'd1) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= CHECK;
                            end
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef CODEC_DMA_IRQ_EN
    // Sticky completion interrupt; a clear coinciding with completion loses.
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            irq <= 1'b0;
        end else if (state == DONE) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_codec_dac_dma_master.sv
// Randomized bench for codec_dac_dma_master: memory slave model + transfer-level reference.
module tb_codec_dac_dma_master;
    import codec_dma_pkg::*;

    localparam int BMAX = 8;
    localparam int FW   = 9;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        cfg_start;
    logic [31:0] cfg_base_addr;
    logic [15:0] cfg_num_words;
    logic [7:0]  cfg_burst_len;
    logic        cfg_abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        irq;
`ifdef CODEC_DMA_IRQ_EN
    logic        irq_clr;
`endif

    codec_dac_dma_master_if #(.FREE_W(FW)) bus ();

    codec_dac_dma_master #(.BURST_MAX(BMAX), .FREE_W(FW)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .cfg_start     (cfg_start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_num_words (cfg_num_words),
        .cfg_burst_len (cfg_burst_len),
        .cfg_abort     (cfg_abort),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
`ifdef CODEC_DMA_IRQ_EN
        .irq_clr       (irq_clr),
`endif
        .irq           (irq),
        .bus           (bus)
    );

    initial forever #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Observed traffic
    logic [31:0] acc_addr_q[$];
    int          acc_len_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] beat_q[$];
    // Expected traffic
    logic [31:0] exp_addr_q[$];
    int          exp_len_q[$];
    logic [31:0] exp_dat_q[$];
    bit          exp_aborted;

    int          wait_mode = 0, gap_mode = 0, free_mode = 0;
    int          hold_left = 0, stall_cnt = 0, done_cnt = 0;
    int          beats_given = 0, abort_beat = 0;
    bit          abort_arm = 0, read_seen = 0, prev_stall = 0;
    bit          done_aborted = 0, done_busy = 0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_bc = '0;
    logic [FW-1:0] free_fixed = FW'(64);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Transfer-level reference: chop the word range into bursts of the
    // effective length; an abort raised in burst 0 stops after that burst.
    task automatic build_model(input logic [31:0] base, input int n, input int blen, input bit ab);
        int l_eff, rem, l;
        logic [31:0] a;
        exp_addr_q.delete(); exp_len_q.delete(); exp_dat_q.delete();
        l_eff = (blen == 0) ? 1 : ((blen > BMAX) ? BMAX : blen);
        a     = base & 32'hFFFF_FFFC;
        rem   = n;
        while (rem > 0) begin
            l = (rem < l_eff) ? rem : l_eff;
            exp_addr_q.push_back(a);
            exp_len_q.push_back(l);
            for (int i = 0; i < l; i++) exp_dat_q.push_back(mem_word(a + 32'(4 * i)));
            a   = a + 32'(4 * l);
            rem = rem - l;
            if (ab) break;
        end
        exp_aborted = ab && (rem > 0);
        abort_beat  = (exp_len_q.size() > 0 && exp_len_q[0] > 1) ? 1 : 0;
    endtask

    // Memory slave + monitors, acting just after each falling edge.
    initial begin : slave_bfm
        logic [31:0] a;
        logic        nw;
        bus.master_waitrequest   = 1'b0;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata      = '0;
        bus.dac_fifo_free        = '0;
        cfg_abort                = 1'b0;
        forever begin
            @(negedge Clk);
            #1;
            if (bus.dac_fifo_wr) fifo_q.push_back(bus.dac_fifo_data);
            if (bus.master_read) read_seen = 1;
            if (done) begin
                done_cnt++;
                done_aborted = aborted;
                done_busy    = busy;
            end
            if (prev_stall) begin
                stall_cnt++;
                chk("req_hold_read", 32'(bus.master_read), 32'd1);
                chk("req_hold_addr", bus.master_address, prev_addr);
                chk("req_hold_bcnt", 32'(bus.master_burstcount), 32'(prev_bc));
            end
            cfg_abort                = 1'b0;
            bus.master_readdatavalid = 1'b0;
            if (beat_q.size() > 0 && (gap_mode == 0 || $urandom_range(0, 3) != 0)) begin
                a = beat_q.pop_front();
                bus.master_readdatavalid = 1'b1;
                bus.master_readdata      = mem_word(a);
                if (abort_arm && beats_given == abort_beat) begin
                    cfg_abort = 1'b1;
                    abort_arm = 0;
                end
                beats_given++;
            end
            nw = 1'b0;
            if (wait_mode == 1) begin
                nw = ($urandom_range(0, 2) == 0);
            end else if (wait_mode == 2 && bus.master_read && hold_left > 0) begin
                nw = 1'b1;
                hold_left--;
            end
            bus.master_waitrequest = nw;
            bus.dac_fifo_free = (free_mode != 0) ? FW'($urandom_range(0, 15)) : free_fixed;
            prev_stall = bus.master_read && nw && !Rst_n;
            prev_addr  = bus.master_address;
            prev_bc    = bus.master_burstcount;
            if (bus.master_read && !nw && !Rst_n) begin
                acc_addr_q.push_back(bus.master_address);
                acc_len_q.push_back(int'(bus.master_burstcount));
                for (int i = 0; i < int'(bus.master_burstcount); i++)
                    beat_q.push_back(bus.master_address + 32'(4 * i));
            end
        end
    end

    task automatic start_xfer(input logic [31:0] base, input int n, input int blen,
                              input bit ab, input int wm, input int gm);
        build_model(base, n, blen, ab);
        @(negedge Clk);
        acc_addr_q.delete(); acc_len_q.delete(); fifo_q.delete(); beat_q.delete();
        done_cnt = 0; beats_given = 0; read_seen = 0; stall_cnt = 0; hold_left = 5;
        abort_arm = ab; wait_mode = wm; gap_mode = gm;
        cfg_base_addr = base;
        cfg_num_words = 16'(n);
        cfg_burst_len = 8'(blen);
        cfg_start     = 1'b1;
        @(negedge Clk);
        cfg_start     = 1'b0;
        // Must be ignored once the transfer is running.
        cfg_base_addr = $urandom;
        cfg_num_words = 16'($urandom);
    endtask

    task automatic finish_xfer();
        int guard;
        guard = 0;
        while (done_cnt == 0 && guard < 4000) begin
            @(negedge Clk);
            guard++;
        end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge Clk);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("aborted", 32'(done_aborted), 32'(exp_aborted));
        chk("busy_at_done", 32'(done_busy), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("burst_count", 32'(acc_addr_q.size()), 32'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size() && i < acc_addr_q.size(); i++) begin
            chk("burst_addr", acc_addr_q[i], exp_addr_q[i]);
            chk("burst_len", 32'(acc_len_q[i]), 32'(exp_len_q[i]));
        end
        chk("fifo_writes", 32'(fifo_q.size()), 32'(exp_dat_q.size()));
        for (int i = 0; i < exp_dat_q.size() && i < fifo_q.size(); i++)
            chk("fifo_data", fifo_q[i], exp_dat_q[i]);
`ifdef CODEC_DMA_IRQ_EN
        chk("irq_set", 32'(irq), 32'd1);
        irq_clr = 1'b1;
        @(negedge Clk);
        irq_clr = 1'b0;
        @(negedge Clk);
        chk("irq_clr", 32'(irq), 32'd0);
`else
        chk("irq_tied", 32'(irq), 32'd0);
`endif
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_aborted"}, 32'(aborted), 32'd0);
        chk({pfx, "_irq"}, 32'(irq), 32'd0);
        chk({pfx, "_read"}, 32'(bus.master_read), 32'd0);
        chk({pfx, "_addr"}, bus.master_address, 32'd0);
        chk({pfx, "_bcnt"}, 32'(bus.master_burstcount), 32'd0);
        chk({pfx, "_fifo_wr"}, 32'(bus.dac_fifo_wr), 32'd0);
        chk({pfx, "_fifo_data"}, bus.dac_fifo_data, 32'd0);
    endtask

    initial begin : main
        int w, g;
        Rst_n = 1'b1;
        cfg_start = 1'b0; cfg_base_addr = '0; cfg_num_words = '0; cfg_burst_len = '0;
`ifdef CODEC_DMA_IRQ_EN
        irq_clr = 1'b0;
`endif
        repeat (3) @(negedge Clk);
        chk_all_zero("reset");
        Rst_n = 1'b0;

        // Three bursts, last one short.
        start_xfer(32'h0000_1000, 20, 8, 0, 0, 0);
        finish_xfer();
        if (acc_addr_q.size() == 3) chk("t1_third_addr", acc_addr_q[2], 32'h0000_1040);

        // Zero-length transfer completes immediately without a request.
        start_xfer(32'h0000_3000, 0, 4, 0, 0, 0);
        chk("zero_done_next", 32'(done), 32'd1);
        finish_xfer();
        chk("zero_no_read", 32'(read_seen), 32'd0);

        // Five-cycle waitrequest stall on a single burst.
        start_xfer(32'h0000_4000, 8, 8, 0, 2, 0);
        finish_xfer();
        chk("stall_cycles", 32'(stall_cnt), 32'd5);

        // Not enough FIFO space: hold in CHECK until space appears.
        free_fixed = FW'(3);
        start_xfer(32'h0000_5000, 16, 8, 0, 0, 0);
        repeat (10) @(negedge Clk);
        chk("free_wait_no_read", 32'(read_seen), 32'd0);
        free_fixed = FW'(8);
        @(negedge Clk);
        chk("free_issue", 32'(bus.master_read), 32'd1);
        finish_xfer();
        free_fixed = FW'(64);

        // Abort during burst 1: burst drains, then stop.
        start_xfer(32'h0000_6000, 16, 4, 1, 0, 0);
        finish_xfer();

        // Address wrap past the top of memory.
        start_xfer(32'hFFFF_FFF8, 4, 2, 0, 0, 0);
        finish_xfer();
        if (acc_addr_q.size() == 2) chk("wrap_addr", acc_addr_q[1], 32'h0000_0000);

        // Reset in the middle of a data phase.
        start_xfer(32'h0000_8000, 16, 8, 0, 0, 0);
        g = 0;
        while (fifo_q.size() < 2 && g < 200) begin
            @(negedge Clk);
            g++;
        end
        chk("rst_in_data", 32'(fifo_q.size() >= 2), 32'd1);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk_all_zero("rst_mid");
        Rst_n = 1'b0;
        w = fifo_q.size();
        repeat (12) @(negedge Clk);
        chk("rst_late_beats", 32'(fifo_q.size()), 32'(w));
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_idle", 32'(busy), 32'd0);

        // Randomized transfers.
        free_mode = 1;
        for (int t = 0; t < 12; t++) begin
            start_xfer($urandom, $urandom_range(0, 40), $urandom_range(0, 12),
                       ($urandom_range(0, 3) == 0), $urandom_range(0, 1), 1);
            finish_xfer();
        end
        free_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/codec_dac_dma_master.md
Name: codec_dac_dma_master

Overview:
- Avalon-MM burst read master that fetches 32-bit stereo DAC samples from system memory and pushes them into the DAC FIFO.
- It is the initiator counterpart of the codec slave register interface.
- Software programs base address, word count and burst length, then pulses start. The block issues bursts sized to fit the FIFO free space and signals completion.

Parameters:
- BURST_MAX, 8, largest burst issued; cfg_burst_len values above it are clipped to it.
- FREE_W, 9, width of the dac_fifo_free input.

Ports:
- Clk  input  1  system clock.
- Rst_n  input  1  reset; synchronous, active-high (asserted when 1).
- cfg_start  input  1  one-cycle start pulse; sampled only in IDLE.
- cfg_base_addr  input  32  byte address of the first word; bits [1:0] ignored.
- cfg_num_words  input  16  total words to transfer.
- cfg_burst_len  input  8  requested burst length; 0 is treated as 1.
- cfg_abort  input  1  stop at the next burst boundary.
- busy  output  1  high from accepted start until DONE exits.
- done  output  1  one-cycle pulse in the DONE state.
- aborted  output  1  set with done if the transfer was cut short; cleared on the next accepted start.
- master_address  output  32  burst start address, word aligned.
- master_read  output  1  read request.
- master_burstcount  output  8  beats in the current burst.
- master_waitrequest  input  1  slave stall.
- master_readdata  input  32  read data.
- master_readdatavalid  input  1  a beat of read data is valid.
- dac_fifo_wr  output  1  FIFO write strobe.
- dac_fifo_data  output  32  FIFO write data.
- dac_fifo_free  input  FREE_W  free FIFO entries.
- irq  output  1  interrupt; see Optional Feature.

Behaviour:
- Reset, synchronous: state=IDLE. busy, done, aborted, master_read, dac_fifo_wr, irq all 0. master_address, master_burstcount, dac_fifo_data all 0. Internal addr/remaining/beat counters 0.
- IDLE:
  - cfg_start=1 latches addr=cfg_base_addr & ~3 and remaining=cfg_num_words, then goes to CHECK.
  - If cfg_num_words=0, go straight to DONE instead.
- CHECK:
  - len = min(max(cfg_burst_len,1), BURST_MAX, remaining).
  - If cfg_abort was seen, go to DONE with aborted=1.
  - Else if dac_fifo_free >= len + beats in flight (0 here), go to REQ next cycle, driving master_address=addr and master_burstcount=len.
  - Else stay in CHECK.
- REQ:
  - master_read=1 and address/burstcount held stable while master_waitrequest=1.
  - On the cycle master_waitrequest=0, the request is accepted: load the beat counter with len, drop master_read, go to DATA.
- DATA:
  - Each master_readdatavalid decrements the beat counter and remaining.
  - On the final beat (counter==1 with valid): addr += 4*len, modulo 2^32 wrap.
  - Then go to DONE if remaining reaches 0, else to CHECK.
  - readdatavalid outside DATA is ignored.
- DONE: done=1 for one cycle, busy falls, return to IDLE.
- FIFO path, registered: each accepted beat drives dac_fifo_wr=1 and dac_fifo_data=master_readdata on the following cycle.
  - No backpressure is needed because space is reserved in CHECK.
  - A beat arriving while the FIFO is full is a system error; the block still writes.
- Abort:
  - cfg_abort is sticky once busy.
  - An in-flight burst always completes, as Avalon requires; abort is honoured only in CHECK.
- cfg_start while busy is ignored. cfg_* inputs are sampled only at start, except cfg_burst_len and cfg_abort.
- Reset asserted mid-burst drops master_read immediately. Late readdatavalid beats after reset are discarded.

Optional Feature:
- Macro CODEC_DMA_IRQ_EN.
- When defined:
  - irq is sticky: set on the done pulse.
  - It is cleared by an added input irq_clr (1 bit).
  - If irq_clr and done occur in the same cycle, set wins.
- When undefined: the irq_clr port is absent and irq is tied to 0.

Decomposition:
- Package codec_dma_pkg holds:
  - state encoding IDLE=0, CHECK=1, REQ=2, DATA=3, DONE=4 (3-bit);
  - WORD_BYTES=4;
  - BCOUNT_W=8.
- One sub-module, codec_burst_counter:
  - 8-bit load/decrement counter;
  - load, dec and last (count==1) signals;
  - used for the beat count.

Test Plan:
- Base 0x1000, 20 words, burst 8, free=64, no wait:
  - bursts at 0x1000/8, 0x1020/8, 0x1040/4;
  - 20 FIFO writes with matching data;
  - one done pulse; aborted=0.
- cfg_num_words=0, start:
  - done on the cycle after start;
  - master_read never asserted.
- master_waitrequest held for 5 cycles during REQ:
  - address and burstcount stable for all 5 cycles;
  - beat counter loads only on the accept cycle.
- free=3, burst 8, 16 words:
  - block waits in CHECK;
  - raising free to 8 issues the burst one cycle later.
- Abort pulsed during the second beat of burst 1 (16 words, burst 4):
  - burst 1 completes with 4 FIFO writes;
  - done with aborted=1;
  - no second request.
- Base 0xFFFFFFF8, 4 words, burst 2:
  - second burst address wraps to 0x00000000.
- Reset asserted mid-DATA:
  - all outputs 0 next cycle; state IDLE;
  - late valid beats produce no FIFO writes.
